// File: rtl/rx_bit_timer.sv
// UART RX bit-timing engine: one sample strobe at the centre of every frame bit,
// with a runtime baud divisor, false-start rejection and a frame-done pulse.
module rx_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 10417,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk_i,
   input  logic             rx_srst_ni,
   input  logic             rx_rst_i,
   input  logic             rx_en_fsm_i,
   input  logic             rx_line_i,
   input  logic [CNT_W-1:0] rx_baud_div_i,
   output logic             rx_sample_tick_o,
   output logic [3:0]       rx_bit_idx_o,
   output logic             rx_frame_done_o,
   output logic             rx_false_start_o,
   output logic             rx_busy_o
);

   localparam int unsigned      FRAME_BITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
   localparam logic [CNT_W-1:0] DefDiv     = CNT_W'(CLKS_PER_BIT);
   localparam logic [3:0]       LastIdx    = 4'(FRAME_BITS - 1);

   typedef enum logic [1:0] {StIdle, StStart, StBits, StDone} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] div_q;
   logic [3:0]       idx_q;
   logic             tick_q;
   logic             done_q;
   logic             fs_q;
   logic [CNT_W-1:0] eff_div;
   logic [3:0]       idx_inc;

   // Divisors below 2 cannot produce a half-bit delay, so fall back to the default.
   assign eff_div = (rx_baud_div_i < CNT_W'(2)) ? DefDiv : rx_baud_div_i;
   assign idx_inc = idx_q + 4'd1;

   always_ff @(posedge clk_i) begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      fs_q   <= 1'b0;
      if (!rx_srst_ni || rx_rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         div_q   <= DefDiv;
      end else if (!rx_en_fsm_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               div_q   <= eff_div;
               cnt_q   <= (eff_div >> 1) - CNT_W'(1);
               state_q <= StStart;
            end
            StStart: begin
               if (cnt_q == '0) begin
                  if (!rx_line_i) begin
                     tick_q  <= 1'b1;
                     idx_q   <= '0;
                     cnt_q   <= div_q - CNT_W'(1);
                     state_q <= StBits;
                  end else begin
                     fs_q    <= 1'b1;
                     state_q <= StDone;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            StBits: begin
               if (cnt_q == '0) begin
                  tick_q <= 1'b1;
                  idx_q  <= idx_inc;
                  cnt_q  <= div_q - CNT_W'(1);
                  if (idx_inc == LastIdx) begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            StDone: begin
               // Parked until enable drops; counter and index frozen.
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign rx_sample_tick_o = tick_q;
   assign rx_bit_idx_o     = idx_q;
   assign rx_frame_done_o  = done_q;
   assign rx_false_start_o = fs_q;
   assign rx_busy_o        = (state_q == StStart) || (state_q == StBits);

endmodule

// File: tb/tb_rx_bit_timer.sv
// Bench for rx_bit_timer: two configurations (8N1 and 7-data/parity/2-stop) driven together,
// checked every cycle against a frame-timing model built from tick-time arithmetic.
module tb_rx_bit_timer;

   localparam int unsigned Cpb  = 16;
   localparam int unsigned CntW = 16;
   localparam int          FbA  = 10;
   localparam int          FbB  = 11;

   logic            clk;
   logic            srst_n;
   logic            rst;
   logic            en;
   logic            line;
   logic [CntW-1:0] baud;

   logic       tick_a, done_a, fs_a, busy_a;
   logic [3:0] idx_a;
   logic       tick_b, done_b, fs_b, busy_b;
   logic [3:0] idx_b;

   rx_bit_timer #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1),
                  .CNT_W(CntW)) dut_a (
      .clk_i(clk), .rx_srst_ni(srst_n), .rx_rst_i(rst), .rx_en_fsm_i(en), .rx_line_i(line),
      .rx_baud_div_i(baud), .rx_sample_tick_o(tick_a), .rx_bit_idx_o(idx_a),
      .rx_frame_done_o(done_a), .rx_false_start_o(fs_a), .rx_busy_o(busy_a)
   );

   rx_bit_timer #(.CLKS_PER_BIT(Cpb), .DATA_BITS(7), .PARITY_EN(1), .STOP_BITS(2),
                  .CNT_W(CntW)) dut_b (
      .clk_i(clk), .rx_srst_ni(srst_n), .rx_rst_i(rst), .rx_en_fsm_i(en), .rx_line_i(line),
      .rx_baud_div_i(baud), .rx_sample_tick_o(tick_b), .rx_bit_idx_o(idx_b),
      .rx_frame_done_o(done_b), .rx_false_start_o(fs_b), .rx_busy_o(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: a frame started at edge e0 with divisor dv ticks at e0 + dv/2 + k*dv.
   bit act  [2];
   bit park [2];
   int e0   [2];
   int dv   [2];
   int x_tick [2], x_idx [2], x_done [2], x_fs [2], x_busy [2];

   int n_tick [2], first_tick [2], done_cyc [2], fs_cyc [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_edge(input int d);
      int fb, t, h;
      fb = (d == 0) ? FbA : FbB;
      x_tick[d] = 0;
      x_done[d] = 0;
      x_fs[d]   = 0;
      if (!srst_n || rst || !en) begin
         act[d]   = 0;
         park[d]  = 0;
         x_idx[d] = 0;
      end else if (act[d]) begin
         t = cyc - e0[d];
         h = dv[d] / 2;
         if (t == h) begin
            if (line) begin
               x_fs[d] = 1;
               act[d]  = 0;
               park[d] = 1;
            end else begin
               x_tick[d] = 1;
               x_idx[d]  = 0;
            end
         end else if (t > h && ((t - h) % dv[d]) == 0) begin
            x_tick[d] = 1;
            x_idx[d]  = (t - h) / dv[d];
            if (x_idx[d] == fb - 1) begin
               x_done[d] = 1;
               act[d]    = 0;
               park[d]   = 1;
            end
         end
      end else if (!park[d]) begin
         act[d] = 1;
         e0[d]  = cyc;
         dv[d]  = (baud < 2) ? Cpb : int'(baud);
      end
      x_busy[d] = act[d] ? 1 : 0;
   endtask

   task automatic clr_obs();
      for (int d = 0; d < 2; d++) begin
         n_tick[d]     = 0;
         first_tick[d] = -1;
         done_cyc[d]   = -1;
         fs_cyc[d]     = -1;
      end
   endtask

   task automatic note(input int d, input logic tk, input logic dn, input logic fs);
      if (tk === 1'b1) begin
         n_tick[d]++;
         if (first_tick[d] < 0) first_tick[d] = cyc;
      end
      if (dn === 1'b1) done_cyc[d] = cyc;
      if (fs === 1'b1) fs_cyc[d] = cyc;
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge(0);
      model_edge(1);
      #1;
      chk("a_tick", {31'b0, tick_a}, x_tick[0]);
      chk("a_idx",  {28'b0, idx_a},  x_idx[0]);
      chk("a_done", {31'b0, done_a}, x_done[0]);
      chk("a_fs",   {31'b0, fs_a},   x_fs[0]);
      chk("a_busy", {31'b0, busy_a}, x_busy[0]);
      chk("b_tick", {31'b0, tick_b}, x_tick[1]);
      chk("b_idx",  {28'b0, idx_b},  x_idx[1]);
      chk("b_done", {31'b0, done_b}, x_done[1]);
      chk("b_fs",   {31'b0, fs_b},   x_fs[1]);
      chk("b_busy", {31'b0, busy_b}, x_busy[1]);
      note(0, tick_a, done_a, fs_a);
      note(1, tick_b, done_b, fs_b);
   endtask

   task automatic run(input int n, input bit rnd_line);
      for (int i = 0; i < n; i++) begin
         if (rnd_line) line = 1'($urandom);
         step();
      end
   endtask

   initial begin
      int s;
      srst_n = 1'b0;
      rst    = 1'b0;
      en     = 1'b0;
      line   = 1'b1;
      baud   = '0;
      for (int d = 0; d < 2; d++) begin
         act[d] = 0; park[d] = 0; e0[d] = 0; dv[d] = Cpb;
      end
      clr_obs();
      run(3, 0);
      srst_n = 1'b1;
      run(2, 0);

      // T1: default divisor, 8N1 frame
      clr_obs();
      line = 1'b0;
      en   = 1'b1;
      step();
      s = cyc;
      run(8, 0);
      run(180, 1);
      chk("t1_done_a_time", done_cyc[0], s + 152);
      chk("t1_ticks_a", n_tick[0], 10);
      chk("t1_ticks_b", n_tick[1], 11);
      en = 1'b0;
      step();

      // T2: runtime divisor 10
      clr_obs();
      baud = 16'd10;
      line = 1'b0;
      en   = 1'b1;
      step();
      s = cyc;
      run(5, 0);
      run(115, 1);
      chk("t2_done_b_time", done_cyc[1], s + 105);
      chk("t2_done_a_time", done_cyc[0], s + 95);
      en = 1'b0;
      step();

      // T3: false start, held enable must not retrigger
      clr_obs();
      baud = '0;
      line = 1'b1;
      en   = 1'b1;
      step();
      s = cyc;
      run(60, 0);
      chk("t3_fs_time", fs_cyc[0], s + 8);
      chk("t3_no_ticks", n_tick[0] + n_tick[1], 0);
      en = 1'b0;
      step();

      // T4: abort after bit index 4
      clr_obs();
      line = 1'b0;
      en   = 1'b1;
      step();
      for (int i = 0; i < 200 && n_tick[0] < 5; i++) step();
      chk("t4_ticks_before", n_tick[0], 5);
      en = 1'b0;
      step();
      chk("t4_idx_cleared", {28'b0, idx_a}, 0);
      run(40, 1);
      chk("t4_no_more_ticks", n_tick[0], 5);
      chk("t4_no_done", done_cyc[0], -1);

      // T5: synchronous reset then synchronous clear, each mid-frame
      for (int r = 0; r < 2; r++) begin
         line = 1'b0;
         en   = 1'b1;
         run(50, 0);
         if (r == 0) srst_n = 1'b0; else rst = 1'b1;
         step();
         chk("t5_busy_cleared", {31'b0, busy_a}, 0);
         srst_n = 1'b1;
         rst    = 1'b0;
         clr_obs();
         line = 1'b0;
         step();
         s = cyc;
         run(30, 0);
         chk("t5_restart_first_tick", first_tick[0], s + 8);
         run(170, 1);
         en = 1'b0;
         step();
      end

      // T6: divisor change mid-frame ignored; next frame picks it up
      clr_obs();
      baud = 16'd16;
      line = 1'b0;
      en   = 1'b1;
      step();
      s = cyc;
      run(30, 0);
      baud = 16'd40;
      run(150, 1);
      chk("t6_done_a_time", done_cyc[0], s + 152);
      en = 1'b0;
      step();
      clr_obs();
      line = 1'b0;
      en   = 1'b1;
      step();
      s = cyc;
      run(25, 0);
      chk("t6_new_div_first_tick", first_tick[0], s + 20);
      en = 1'b0;
      step();

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 3) en = ~en;
         if ($urandom_range(0, 3) == 0) line = 1'($urandom);
         if ($urandom_range(0, 49) == 0) baud = CntW'($urandom_range(0, 24));
         srst_n = ($urandom_range(0, 399) != 0);
         rst    = ($urandom_range(0, 399) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
